// File: rtl/regfile_write_buffer_pkg.sv
// Shared widths, constants and the buffered-write entry type for the regfile write buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_write_buffer_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int RF_DEPTH = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // One posted register write: destination register and the value to commit.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/wbuf_lookup.sv
// Priority matcher: finds the youngest valid buffered write to a queried register.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module wbuf_lookup
    import regfile_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  entry_t                entries [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      tail,
    input  logic [ADDR_W-1:0]     query,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [PTR_W-1:0] idx;

    // Walk from the oldest slot (tail - DEPTH) to the youngest (tail - 1); later matches override,
    // so the entry closest to the tail wins. $zero is never forwarded.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PTR_W'(k);
            if (valid[idx] && (entries[idx].addr == query) && (query != ZERO_REG)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// Posted-write FIFO in front of the register file, with two forwarding lookups for the read ports.
// Latency: enqueue edge to commit edge is 1 cycle minimum; lookups are combinational on registered state.
// Backpressure: EnqReady drops when full (registered state only); DrainEnable low stalls the drain.
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = regfile_write_buffer_pkg::ADDR_W,
    parameter int DATA_W = regfile_write_buffer_pkg::DATA_W
) (
    input  logic                     Clk,
    input  logic                     ResetN,
    input  logic                     EnqValid,
    output logic                     EnqReady,
    input  logic [ADDR_W-1:0]        EnqRegister,
    input  logic [DATA_W-1:0]        EnqData,
    input  logic                     DrainEnable,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [ADDR_W-1:0]        LookupRegister1,
    input  logic [ADDR_W-1:0]        LookupRegister2,
    output logic                     Hit1,
    output logic                     Hit2,
    output logic [DATA_W-1:0]        HitData1,
    output logic [DATA_W-1:0]        HitData2,
    output logic [$clog2(DEPTH):0]   Count
);

    import regfile_write_buffer_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;

    logic               not_empty;
    logic               full;
    logic               enq_fire;
    logic               enq_store;
    logic               drain;

    assign not_empty = (cnt != '0);
    assign full      = (cnt == CNT_W'(DEPTH));

    // Ready comes from the registered count alone, so a full buffer refuses even while draining.
    assign EnqReady  = !full;
    assign enq_fire  = EnqValid && !full;
    // Writes to $zero complete the handshake but are dropped.
    assign enq_store = enq_fire && (EnqRegister != ZERO_REG);
    assign drain     = DrainEnable && not_empty;

    assign RegWrite      = drain;
    assign WriteRegister = not_empty ? entries[head].addr : '0;
    assign WriteData     = not_empty ? entries[head].data : '0;
    assign Count         = cnt;

    // Pointers, occupancy and valid bits; reset discards everything still pending.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (enq_store) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            cnt <= cnt + CNT_W'(enq_store) - CNT_W'(drain);
        end
    end

    // Entry payload storage; never read while its valid bit is clear, so it is left unreset.
    always_ff @(posedge Clk) begin
        if (enq_store) begin
            entries[tail] <= '{addr: EnqRegister, data: EnqData};
        end
    end

    wbuf_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup1 (
        .entries (entries),
        .valid   (valid),
        .tail    (tail),
        .query   (LookupRegister1),
        .hit     (Hit1),
        .data    (HitData1)
    );

    wbuf_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lookup2 (
        .entries (entries),
        .valid   (valid),
        .tail    (tail),
        .query   (LookupRegister2),
        .hit     (Hit2),
        .data    (HitData2)
    );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer: vector table, scoreboard monitor and corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        EnqValid;
    logic        EnqReady;
    logic [4:0]  EnqRegister;
    logic [31:0] EnqData;
    logic        DrainEnable;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  LookupRegister1;
    logic [4:0]  LookupRegister2;
    logic        Hit1;
    logic        Hit2;
    logic [31:0] HitData1;
    logic [31:0] HitData2;
    logic [2:0]  Count;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .Clk             (Clk),
        .ResetN          (ResetN),
        .EnqValid        (EnqValid),
        .EnqReady        (EnqReady),
        .EnqRegister     (EnqRegister),
        .EnqData         (EnqData),
        .DrainEnable     (DrainEnable),
        .RegWrite        (RegWrite),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .LookupRegister1 (LookupRegister1),
        .LookupRegister2 (LookupRegister2),
        .Hit1            (Hit1),
        .Hit2            (Hit2),
        .HitData1        (HitData1),
        .HitData2        (HitData2),
        .Count           (Count)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard of pending writes, oldest at the front.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } sb_t;
    sb_t sb[$];

    function automatic void model_lookup(input logic [4:0] q, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (q != 5'd0) begin
            foreach (sb[i]) begin
                if (sb[i].r == q) begin
                    h = 1'b1;
                    d = sb[i].d;
                end
            end
        end
    endfunction

    logic mon_en = 1'b0;
    logic rw_watch = 1'b0;
    int   rw_seen = 0;

    always @(negedge ResetN) sb.delete();

    // Monitor: compare every cycle against the scoreboard, then advance it as the edge will.
    always @(negedge Clk) begin : mon
        int          m_n;
        logic        m_rw;
        logic        m_h;
        logic [31:0] m_d;
        sb_t         e;
        if (mon_en && ResetN) begin
            m_n = sb.size();
            chk("sb_ready", {63'd0, EnqReady}, {63'd0, (m_n != DEPTH)});
            chk("sb_count", {61'd0, Count}, 64'(m_n));
            m_rw = DrainEnable && (m_n != 0);
            chk("sb_regwrite", {63'd0, RegWrite}, {63'd0, m_rw});
            if (rw_watch && RegWrite) rw_seen++;
            if (m_n != 0) begin
                chk("sb_wreg", {59'd0, WriteRegister}, {59'd0, sb[0].r});
                chk("sb_wdata", {32'd0, WriteData}, {32'd0, sb[0].d});
            end else begin
                chk("sb_wreg_empty", {59'd0, WriteRegister}, 64'd0);
                chk("sb_wdata_empty", {32'd0, WriteData}, 64'd0);
            end
            model_lookup(LookupRegister1, m_h, m_d);
            chk("sb_hit1", {63'd0, Hit1}, {63'd0, m_h});
            chk("sb_hitdata1", {32'd0, HitData1}, {32'd0, m_d});
            model_lookup(LookupRegister2, m_h, m_d);
            chk("sb_hit2", {63'd0, Hit2}, {63'd0, m_h});
            chk("sb_hitdata2", {32'd0, HitData2}, {32'd0, m_d});
            if (m_rw) void'(sb.pop_front());
            if (EnqValid && (m_n != DEPTH) && (EnqRegister != 5'd0)) begin
                e.r = EnqRegister;
                e.d = EnqData;
                sb.push_back(e);
            end
        end
    end

    typedef struct {
        logic        ev;
        logic [4:0]  er;
        logic [31:0] ed;
        logic        de;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        x_rdy;
        logic [2:0]  x_cnt;
        logic        x_rw;
        logic [4:0]  x_wr;
        logic [31:0] x_wd;
        logic        x_h1;
        logic [31:0] x_hd1;
        logic        x_h2;
        logic [31:0] x_hd2;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic ev, input logic [4:0] er, input logic [31:0] ed, input logic de,
                                input logic [4:0] l1, input logic [4:0] l2, input logic [2:0] x_cnt,
                                input logic x_rw, input logic [4:0] x_wr, input logic [31:0] x_wd,
                                input logic x_h1, input logic [31:0] x_hd1, input logic x_h2,
                                input logic [31:0] x_hd2);
        vec_t v;
        v.ev = ev; v.er = er; v.ed = ed; v.de = de; v.l1 = l1; v.l2 = l2;
        v.x_rdy = 1'b1; v.x_cnt = x_cnt; v.x_rw = x_rw; v.x_wr = x_wr; v.x_wd = x_wd;
        v.x_h1 = x_h1; v.x_hd1 = x_hd1; v.x_h2 = x_h2; v.x_hd2 = x_hd2;
        return v;
    endfunction

    task automatic put(input logic [4:0] r, input logic [31:0] d, input logic de);
        EnqValid    = 1'b1;
        EnqRegister = r;
        EnqData     = d;
        DrainEnable = de;
        @(posedge Clk); #1;
        EnqValid    = 1'b0;
    endtask

    initial begin
        int  n;
        logic acc;
        ResetN = 1'b0; EnqValid = 1'b0; EnqRegister = '0; EnqData = '0;
        DrainEnable = 1'b1; LookupRegister1 = '0; LookupRegister2 = '0;

        // Reset state
        #12;
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_count", {61'd0, Count}, 64'd0);
        chk("rst_ready", {63'd0, EnqReady}, 64'd1);
        chk("rst_hit1", {63'd0, Hit1}, 64'd0);
        chk("rst_hitdata1", {32'd0, HitData1}, 64'd0);
        chk("rst_hit2", {63'd0, Hit2}, 64'd0);
        @(posedge Clk); #1;
        ResetN = 1'b1;
        mon_en = 1'b1;
        @(posedge Clk); #1;

        // Idle: no lookup address hits
        for (int a = 0; a < 32; a++) begin
            LookupRegister1 = 5'(a);
            #0.1;
            chk($sformatf("idle_hit1_r%0d", a), {63'd0, Hit1}, 64'd0);
        end
        @(posedge Clk); #1;

        //            ev   er  ed            de  l1 l2 cnt rw wr  wd            h1 hd1           h2 hd2
        vecs.push_back(mk(0, 0, 0,            1, 0, 7, 0, 0, 0, 0,            0, 0,            0, 0));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 5, 7, 0, 0, 0, 0,            0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 5, 7, 1, 0, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 5, 7, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 5, 7, 0, 0, 0, 0,            0, 0,            0, 0));
        vecs.push_back(mk(1, 3, 1,            0, 5, 3, 0, 0, 0, 0,            0, 0,            0, 0));
        vecs.push_back(mk(1, 3, 2,            0, 5, 3, 1, 0, 3, 1,            0, 0,            1, 1));
        vecs.push_back(mk(1, 3, 3,            0, 5, 3, 2, 0, 3, 1,            0, 0,            1, 2));
        vecs.push_back(mk(0, 0, 0,            0, 5, 3, 3, 0, 3, 1,            0, 0,            1, 3));
        vecs.push_back(mk(0, 0, 0,            1, 5, 3, 3, 1, 3, 1,            0, 0,            1, 3));
        vecs.push_back(mk(0, 0, 0,            1, 5, 3, 2, 1, 3, 2,            0, 0,            1, 3));
        vecs.push_back(mk(0, 0, 0,            1, 5, 3, 1, 1, 3, 3,            0, 0,            1, 3));
        vecs.push_back(mk(0, 0, 0,            1, 5, 3, 0, 0, 0, 0,            0, 0,            0, 0));
        vecs.push_back(mk(1, 0, 32'h1234,     1, 0, 3, 0, 0, 0, 0,            0, 0,            0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 0, 3, 0, 0, 0, 0,            0, 0,            0, 0));

        foreach (vecs[i]) begin
            EnqValid = vecs[i].ev; EnqRegister = vecs[i].er; EnqData = vecs[i].ed;
            DrainEnable = vecs[i].de; LookupRegister1 = vecs[i].l1; LookupRegister2 = vecs[i].l2;
            @(negedge Clk);
            chk($sformatf("v%0d_ready", i), {63'd0, EnqReady}, {63'd0, vecs[i].x_rdy});
            chk($sformatf("v%0d_count", i), {61'd0, Count}, {61'd0, vecs[i].x_cnt});
            chk($sformatf("v%0d_regwrite", i), {63'd0, RegWrite}, {63'd0, vecs[i].x_rw});
            chk($sformatf("v%0d_wreg", i), {59'd0, WriteRegister}, {59'd0, vecs[i].x_wr});
            chk($sformatf("v%0d_wdata", i), {32'd0, WriteData}, {32'd0, vecs[i].x_wd});
            chk($sformatf("v%0d_hit1", i), {63'd0, Hit1}, {63'd0, vecs[i].x_h1});
            chk($sformatf("v%0d_hitdata1", i), {32'd0, HitData1}, {32'd0, vecs[i].x_hd1});
            chk($sformatf("v%0d_hit2", i), {63'd0, Hit2}, {63'd0, vecs[i].x_h2});
            chk($sformatf("v%0d_hitdata2", i), {32'd0, HitData2}, {32'd0, vecs[i].x_hd2});
            @(posedge Clk); #1;
        end
        EnqValid = 1'b0;

        // Full buffer: simultaneous drain does not admit the waiting request
        LookupRegister1 = 5'd4; LookupRegister2 = 5'd6;
        put(5'd1, 32'd10, 1'b0);
        put(5'd2, 32'd20, 1'b0);
        put(5'd4, 32'd40, 1'b0);
        put(5'd6, 32'd60, 1'b0);
        DrainEnable = 1'b0;
        #1;
        chk("full_ready", {63'd0, EnqReady}, 64'd0);
        chk("full_count", {61'd0, Count}, 64'd4);
        chk("full_hitdata1", {32'd0, HitData1}, 64'd40);
        EnqValid = 1'b1; EnqRegister = 5'd7; EnqData = 32'd70; DrainEnable = 1'b1;
        #1;
        chk("full_drain_ready", {63'd0, EnqReady}, 64'd0);
        chk("full_drain_regwrite", {63'd0, RegWrite}, 64'd1);
        chk("full_drain_wdata", {32'd0, WriteData}, 64'd10);
        @(posedge Clk); #1;
        chk("after_full_count", {61'd0, Count}, 64'd3);
        chk("after_full_ready", {63'd0, EnqReady}, 64'd1);
        DrainEnable = 1'b0;
        @(posedge Clk); #1;
        chk("accept_count", {61'd0, Count}, 64'd4);

        // Eight more accepted writes while draining, across pointer wrap
        n = 0;
        DrainEnable = 1'b1;
        for (int c = 0; c < 40 && n < 8; c++) begin
            EnqValid = 1'b1; EnqRegister = 5'(8 + n); EnqData = 32'(100 + n);
            #1;
            acc = EnqReady;
            @(posedge Clk); #1;
            if (acc) n++;
        end
        chk("wrap_accepted", 64'(n), 64'd8);
        EnqValid = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("wrap_drained_count", {61'd0, Count}, 64'd0);

        // Asynchronous reset with writes pending: nothing reaches the regfile
        LookupRegister1 = 5'd9;
        put(5'd9,  32'hA9, 1'b0);
        put(5'd10, 32'hAA, 1'b0);
        put(5'd11, 32'hAB, 1'b0);
        chk("pre_reset_count", {61'd0, Count}, 64'd3);
        #1;
        ResetN = 1'b0;
        DrainEnable = 1'b1;
        #1;
        chk("midrst_count", {61'd0, Count}, 64'd0);
        chk("midrst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("midrst_wdata", {32'd0, WriteData}, 64'd0);
        chk("midrst_ready", {63'd0, EnqReady}, 64'd1);
        chk("midrst_hit1", {63'd0, Hit1}, 64'd0);
        @(posedge Clk); #1;
        ResetN = 1'b1;
        rw_watch = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        rw_watch = 1'b0;
        chk("post_reset_regwrites", 64'(rw_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Posted-write FIFO directly upstream of the 32x32 MIPS register file.
- Accepts register-write requests from the execute/memory stages over a valid/ready handshake.
- Drains one request per cycle into the regfile's single synchronous write port (RegWrite / WriteRegister / WriteData).
- Provides two combinational forwarding lookups so read ports see pending, not-yet-committed data.

Parameters:
- DEPTH, 4, number of buffered writes; power of 2, minimum 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- Clk  input  1  clock; all state updates on the positive edge.
- ResetN  input  1  asynchronous, active-low reset.
- EnqValid  input  1  producer has a write request.
- EnqReady  output  1  buffer can accept a request this cycle.
- EnqRegister  input  ADDR_W  destination register of the request.
- EnqData  input  DATA_W  data of the request.
- DrainEnable  input  1  downstream permits a commit this cycle; low stalls draining.
- RegWrite  output  1  write enable to the regfile.
- WriteRegister  output  ADDR_W  regfile write address (head entry).
- WriteData  output  DATA_W  regfile write data (head entry).
- LookupRegister1  input  ADDR_W  forwarding query 1; tied to ReadRegister1.
- LookupRegister2  input  ADDR_W  forwarding query 2; tied to ReadRegister2.
- Hit1  output  1  a pending write to LookupRegister1 exists.
- Hit2  output  1  a pending write to LookupRegister2 exists.
- HitData1  output  DATA_W  youngest pending data for LookupRegister1; 0 when Hit1 is low.
- HitData2  output  DATA_W  youngest pending data for LookupRegister2; 0 when Hit2 is low.
- Count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (ResetN low, asynchronous):
  - Head/tail pointers and Count go to 0; all entry valid bits are cleared.
  - RegWrite=0, Hit1=Hit2=0, HitData1=HitData2=0, EnqReady=1.
  - Entry data need not be cleared.
  - Reset asserted mid-operation discards all pending writes; none reach the regfile.
- Storage: circular buffer of DEPTH entries {register, data}; pointers wrap modulo DEPTH.
- EnqReady = (Count != DEPTH).
  - Registered-state only, with no combinational path from DrainEnable.
  - When full, a simultaneous drain does NOT admit a new request that cycle.
- Enqueue occurs at the edge when EnqValid & EnqReady.
  - EnqRegister==0: the handshake completes but nothing is stored, since writes to $zero are dropped. Count is unchanged.
- Drain outputs, combinational from the head entry:
  - RegWrite = DrainEnable & (Count != 0).
  - WriteRegister and WriteData = head entry, and 0 when the buffer is empty.
  - The regfile commits on the same edge that pops the head, so latency is 1 cycle minimum from enqueue edge to commit edge.
- Simultaneous enqueue and drain (not full): both occur; Count is unchanged.
- Order: strictly FIFO; no coalescing of same-register writes.
- Lookup:
  - Combinational compare of LookupRegisterN against all valid entries.
  - The youngest match (closest to tail) wins.
  - The head entry being drained this cycle still hits, because the regfile updates only at the edge.
  - LookupRegisterN==0 never hits.
  - The current-cycle enqueue is not visible until the next cycle (no enqueue-to-lookup bypass).
- Count is a registered count; its increment/decrement rules match the enqueue and drain rules above.

Decomposition:
- Shared package / include: ADDR_W=5, DATA_W=32, ZERO_REG=5'd0, the regfile depth constant of 32, and the entry struct {register, data}.
- One sub-module: wbuf_lookup.
  - Parameterised priority matcher: takes the entry array, valid vector, tail pointer and query address; returns hit and data.
  - Instantiated twice, once per read port.

Test Plan:
- Reset then idle, DrainEnable=1 -> RegWrite=0, Count=0, EnqReady=1, Hit1=0 for all lookup addresses.
- Enqueue {r5, 0xDEADBEEF} with DrainEnable=0 -> next cycle Count=1, Hit1=1 with HitData1=0xDEADBEEF at LookupRegister1=5, RegWrite=0; then raise DrainEnable -> RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, and Count=0 after the edge.
- Enqueue {r3,1}, {r3,2}, {r3,3} with DrainEnable=0 -> HitData2=3 at LookupRegister2=3; drain in order -> commits 1, 2, 3 on consecutive edges; during the final commit Hit2=1 and HitData2=3.
- Fill 4 entries with DrainEnable=0 -> EnqReady=0, Count=4; EnqValid held with DrainEnable=1 -> that cycle no enqueue, head pops, Count=3; next cycle EnqReady=1 and the request is accepted; across 8 further operations verify commit order through pointer wrap.
- Enqueue {r0, 0x1234} -> handshake completes, Count stays 0, RegWrite never asserts, and LookupRegister1=0 gives Hit1=0.
- Three entries pending, then ResetN pulsed low mid-cycle -> outputs clear immediately without a clock edge; after release no RegWrite occurs.
